// File: rtl/multiword_add_seq.sv
// Multi-word adder sequencer: feeds an external N-bit adder one word at a
// time (LSW first), chaining the carry through the adder's own carry-out,
// and presents the full WORDS*N-bit sum with a valid/ready handshake.
module multiword_add_seq #(
  parameter int unsigned N       = 32,
  parameter int unsigned WORDS   = 4,
  parameter int unsigned ADD_LAT = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  // Request side
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [N*WORDS-1:0]   op_a,
  input  logic [N*WORDS-1:0]   op_b,
  input  logic                 op_cin,
  // External adder
  output logic [N-1:0]         add_a,
  output logic [N-1:0]         add_b,
  output logic                 add_cin,
  input  logic [N-1:0]         add_sum,
  input  logic                 add_cout,
  // Result side
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [N*WORDS-1:0]   result,
  output logic                 result_cout,
  output logic                 busy
);

  localparam int unsigned IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);
  // Value of the wait counter in the final WAIT cycle of a word.
  localparam logic [2:0] LAT_LAST = (ADD_LAT == 0) ? 3'd0 : 3'(ADD_LAT - 1);

  if (WORDS < 2 || WORDS > 16 || ADD_LAT > 7) begin : g_param_check
    $error("multiword_add_seq: WORDS must be 2..16 and ADD_LAT 0..7");
  end

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StDone} state_e;

  state_e             r_state;
  logic [IDX_W-1:0]   r_idx;
  logic [2:0]         r_wcnt;
  logic               r_carry;
  logic [N-1:0]       r_a   [WORDS];
  logic [N-1:0]       r_b   [WORDS];
  logic [N-1:0]       r_res [WORDS];
  logic               r_out_valid;
  logic               r_result_cout;

  logic               w_active;
  logic               w_last_cycle;

  // Decode of the current state into the word-sequencing qualifiers.
  always_comb begin
    w_active     = (r_state == StIssue) || (r_state == StWait);
    // With zero latency the adder result is sampled at the end of ISSUE.
    w_last_cycle = ((r_state == StIssue) && (ADD_LAT == 0)) ||
                   ((r_state == StWait) && (r_wcnt == LAT_LAST));
  end

  // Adder drive: latched word and running carry while a word is in flight, zero otherwise.
  always_comb begin
    add_a   = '0;
    add_b   = '0;
    add_cin = 1'b0;
    if (w_active) begin
      add_a   = r_a[r_idx];
      add_b   = r_b[r_idx];
      add_cin = r_carry;
    end
  end

  // Handshake and result outputs.
  always_comb begin
    in_ready    = (r_state == StIdle);
    busy        = (r_state != StIdle);
    out_valid   = r_out_valid;
    result_cout = r_result_cout;
    for (int i = 0; i < WORDS; i++) begin
      result[i*N +: N] = r_res[i];
    end
  end

  // Sequencer FSM: latch operands, step through words, hold result until taken.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= StIdle;
      r_idx         <= '0;
      r_wcnt        <= '0;
      r_carry       <= 1'b0;
      r_out_valid   <= 1'b0;
      r_result_cout <= 1'b0;
      for (int i = 0; i < WORDS; i++) begin
        r_a[i]   <= '0;
        r_b[i]   <= '0;
        r_res[i] <= '0;
      end
    end else begin
      unique case (r_state)
        StIdle: begin
          if (in_valid) begin
            for (int i = 0; i < WORDS; i++) begin
              r_a[i] <= op_a[i*N +: N];
              r_b[i] <= op_b[i*N +: N];
            end
            r_idx   <= '0;
            r_wcnt  <= '0;
            r_carry <= op_cin;
            r_state <= StIssue;
          end
        end
        StIssue, StWait: begin
          if (w_last_cycle) begin
            r_res[r_idx] <= add_sum;
            r_carry      <= add_cout;
            if (r_idx == LAST_IDX) begin
              r_result_cout <= add_cout;
              r_out_valid   <= 1'b1;
              r_state       <= StDone;
            end else begin
              r_idx   <= r_idx + 1'b1;
              r_state <= StIssue;
            end
          end else if (r_state == StIssue) begin
            r_wcnt  <= '0;
            r_state <= StWait;
          end else begin
            r_wcnt <= r_wcnt + 3'd1;
          end
        end
        StDone: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= StIdle;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_multiword_add_seq.sv
// Directed bench: a registered-adder instance (ADD_LAT=1) and a
// combinational-adder instance (ADD_LAT=0), checked with immediate assertions.
module tb_multiword_add_seq;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // ---------------- ADD_LAT=1 instance ----------------
  logic         d1_in_valid, d1_in_ready, d1_op_cin;
  logic [127:0] d1_op_a, d1_op_b, d1_result;
  logic [31:0]  d1_add_a, d1_add_b, d1_add_sum;
  logic         d1_add_cin, d1_add_cout;
  logic         d1_out_valid, d1_out_ready, d1_result_cout, d1_busy;

  multiword_add_seq #(.N(32), .WORDS(4), .ADD_LAT(1)) u_dut1 (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (d1_in_valid),
    .in_ready   (d1_in_ready),
    .op_a       (d1_op_a),
    .op_b       (d1_op_b),
    .op_cin     (d1_op_cin),
    .add_a      (d1_add_a),
    .add_b      (d1_add_b),
    .add_cin    (d1_add_cin),
    .add_sum    (d1_add_sum),
    .add_cout   (d1_add_cout),
    .out_valid  (d1_out_valid),
    .out_ready  (d1_out_ready),
    .result     (d1_result),
    .result_cout(d1_result_cout),
    .busy       (d1_busy)
  );

  // Registered 32-bit adder model.
  always_ff @(posedge clk) begin
    {d1_add_cout, d1_add_sum} <= {1'b0, d1_add_a} + {1'b0, d1_add_b} + {32'd0, d1_add_cin};
  end

  // ---------------- ADD_LAT=0 instance ----------------
  logic         d0_in_valid, d0_in_ready, d0_op_cin;
  logic [127:0] d0_op_a, d0_op_b, d0_result;
  logic [31:0]  d0_add_a, d0_add_b, d0_add_sum;
  logic         d0_add_cin, d0_add_cout;
  logic         d0_out_valid, d0_out_ready, d0_result_cout, d0_busy;

  multiword_add_seq #(.N(32), .WORDS(4), .ADD_LAT(0)) u_dut0 (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (d0_in_valid),
    .in_ready   (d0_in_ready),
    .op_a       (d0_op_a),
    .op_b       (d0_op_b),
    .op_cin     (d0_op_cin),
    .add_a      (d0_add_a),
    .add_b      (d0_add_b),
    .add_cin    (d0_add_cin),
    .add_sum    (d0_add_sum),
    .add_cout   (d0_add_cout),
    .out_valid  (d0_out_valid),
    .out_ready  (d0_out_ready),
    .result     (d0_result),
    .result_cout(d0_result_cout),
    .busy       (d0_busy)
  );

  // Combinational 32-bit adder model.
  assign {d0_add_cout, d0_add_sum} = {1'b0, d0_add_a} + {1'b0, d0_add_b} + {32'd0, d0_add_cin};

  // ---------------- check helpers ----------------
  task automatic chk_w(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_b(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_i(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a request to the ADD_LAT=1 instance, scramble operands after acceptance,
  // then wait (bounded) for out_valid. cinmask[k] = add_cin seen in word k's ISSUE cycle.
  task automatic run1(input logic [127:0] a, input logic [127:0] b, input logic cin,
                      output int edges, output logic [3:0] cinmask);
    d1_op_a     = a;
    d1_op_b     = b;
    d1_op_cin   = cin;
    d1_in_valid = 1'b1;
    tick();
    d1_in_valid = 1'b0;
    d1_op_a     = {4{$urandom()}};
    d1_op_b     = {4{$urandom()}};
    d1_op_cin   = ~cin;
    edges   = 0;
    cinmask = 4'b0000;
    while (!d1_out_valid && edges < 20) begin
      if (edges < 8 && edges % 2 == 0) cinmask = {d1_add_cin, cinmask[3:1]};
      tick();
      edges++;
    end
  endtask

  int          edges;
  logic [3:0]  cinmask;
  logic [127:0] held;
  int          spurious;

  initial begin
    rst = 1'b1;
    d1_in_valid = 1'b0; d1_op_a = '0; d1_op_b = '0; d1_op_cin = 1'b0; d1_out_ready = 1'b0;
    d0_in_valid = 1'b0; d0_op_a = '0; d0_op_b = '0; d0_op_cin = 1'b0; d0_out_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    chk_b("rst_in_ready", d1_in_ready, 1'b1);
    chk_b("rst_busy", d1_busy, 1'b0);
    chk_b("rst_out_valid", d1_out_valid, 1'b0);
    chk_w("rst_result", d1_result, 128'd0);
    chk_b("rst_result_cout", d1_result_cout, 1'b0);
    chk_w("rst_add_a", {96'd0, d1_add_a}, 128'd0);
    chk_b("rst_add_cin", d1_add_cin, 1'b0);

    // All-ones + 1: carry ripples through every word; out_ready held high beforehand
    d1_out_ready = 1'b1;
    run1({128{1'b1}}, 128'd1, 1'b0, edges, cinmask);
    chk_i("t1_latency", edges, 8);
    chk_w("t1_result", d1_result, 128'd0);
    chk_b("t1_cout", d1_result_cout, 1'b1);
    chk_w("t1_cinmask", {124'd0, cinmask}, 128'h0000_0000_0000_0000_0000_0000_0000_000e);
    tick();
    chk_b("t1_back_idle", d1_in_ready, 1'b1);
    chk_b("t1_ov_drop", d1_out_valid, 1'b0);

    // Carry from word 0 into word 1 only
    run1(128'h0000_0000_0000_0000_0000_0000_FFFF_FFFF, 128'd1, 1'b0, edges, cinmask);
    chk_i("t2_latency", edges, 8);
    chk_w("t2_result", d1_result, 128'h0000_0000_0000_0000_0000_0001_0000_0000);
    chk_b("t2_cout", d1_result_cout, 1'b0);
    chk_w("t2_cinmask", {124'd0, cinmask}, 128'h2);
    tick();
    chk_b("t2_back_idle", d1_in_ready, 1'b1);

    // Carry-in only, then hold the result for 5 cycles with in_valid pressing
    d1_out_ready = 1'b0;
    run1(128'd0, 128'd0, 1'b1, edges, cinmask);
    chk_i("t3_latency", edges, 8);
    chk_w("t3_result", d1_result, 128'd1);
    chk_b("t3_cout", d1_result_cout, 1'b0);
    chk_w("t3_cinmask", {124'd0, cinmask}, 128'h1);
    held = d1_result;
    d1_in_valid = 1'b1;
    d1_op_a = 128'h5555;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk_b("t3_hold_ov", d1_out_valid, 1'b1);
      chk_w("t3_hold_res", d1_result, held);
      chk_b("t3_hold_cout", d1_result_cout, 1'b0);
      chk_b("t3_hold_inrdy", d1_in_ready, 1'b0);
    end
    d1_in_valid = 1'b0;
    d1_out_ready = 1'b1;
    tick();
    chk_b("t3_handoff_ov", d1_out_valid, 1'b0);
    chk_b("t3_handoff_inrdy", d1_in_ready, 1'b1);
    chk_w("t3_handoff_res", d1_result, 128'd1);

    // Reset in the 3rd cycle after acceptance
    d1_op_a = 128'h1234; d1_op_b = 128'h1; d1_op_cin = 1'b0;
    d1_in_valid = 1'b1;
    tick();
    d1_in_valid = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_b("t4_ov", d1_out_valid, 1'b0);
    chk_b("t4_busy", d1_busy, 1'b0);
    chk_b("t4_inrdy", d1_in_ready, 1'b1);
    chk_w("t4_add_ab", {64'd0, d1_add_a, d1_add_b}, 128'd0);
    chk_b("t4_add_cin", d1_add_cin, 1'b0);
    spurious = 0;
    for (int i = 0; i < 10; i++) begin
      if (d1_out_valid) spurious++;
      tick();
    end
    chk_i("t4_no_stale_ov", spurious, 0);

    // Mixed-carry request after reset
    run1(128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210,
         128'h1111_1111_1111_1111_1111_1111_1111_1111, 1'b0, edges, cinmask);
    chk_i("t5_latency", edges, 8);
    chk_w("t5_result", d1_result, 128'h1234_5678_9ABC_DF01_0FED_CBA9_8765_4321);
    chk_b("t5_cout", d1_result_cout, 1'b0);
    chk_w("t5_cinmask", {124'd0, cinmask}, 128'h4);
    tick();

    // ADD_LAT=0 with combinational adder
    chk_b("z_idle_inrdy", d0_in_ready, 1'b1);
    d0_out_ready = 1'b0;
    d0_op_a = {4{32'h8000_0000}};
    d0_op_b = {4{32'h8000_0000}};
    d0_op_cin = 1'b0;
    d0_in_valid = 1'b1;
    tick();
    d0_in_valid = 1'b0;
    d0_op_a = '0;
    d0_op_b = '0;
    edges = 0;
    while (!d0_out_valid && edges < 20) begin
      tick();
      edges++;
    end
    chk_i("z_latency", edges, 4);
    chk_w("z_result", d0_result, 128'h0000_0001_0000_0001_0000_0001_0000_0000);
    chk_b("z_cout", d0_result_cout, 1'b1);
    chk_w("z_add_idle_done", {95'd0, d0_add_cin, d0_add_a}, 128'd0);
    d0_out_ready = 1'b1;
    tick();
    chk_b("z_handoff_inrdy", d0_in_ready, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
